card_shoe: RTL

CARD_SHOE -- requirements
Module: card_shoe

---
 rtl/card_shoe_if.sv | 17 +
 rtl/card_shoe.sv | 93 +++++++++
 2 files changed

// File: rtl/card_shoe_if.sv
// card_shoe_if: deal handshake and shoe status bundle between a dealer client and card_shoe.
//   deal_req   client -> shoe  level request for one card (four-phase with deal_ack)
//   reshuffle  client -> shoe  return every dealt card to the shoe
//   new_card   shoe -> client  rank of last dealt card (1=A..13=K, 0=none)
//   deal_ack   shoe -> client  high while a freshly dealt card is presented
//   cards_left shoe -> client  cards remaining, 0..52
//   shoe_empty shoe -> client  high when no deal can complete
interface card_shoe_if;
  logic       deal_req;
  logic       reshuffle;
  logic [3:0] new_card;
  logic       deal_ack;
  logic [5:0] cards_left;
  logic       shoe_empty;
  modport master (output deal_req, reshuffle, input new_card, deal_ack, cards_left, shoe_empty);
  modport slave (input deal_req, reshuffle, output new_card, deal_ack, cards_left, shoe_empty);
endinterface

// File: rtl/card_shoe.sv
// card_shoe: 52-card shoe dealing one card per four-phase request, card chosen by request timing.
//   clock  rising-edge clock
//   resetb synchronous active-low reset
//   bus    card_shoe_if.slave (deal_req, reshuffle in; new_card, deal_ack, cards_left, shoe_empty out)
// Macro CARD_SHOE_TRACK_EN: deal without replacement using a 52-bit used mask;
// when undefined the shoe is infinite and never empties.
module card_shoe (
  input logic        clock,
  input logic        resetb,
  card_shoe_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, ACK, EMPTY} state_t;
  state_t state;
  // positions are kept as rank 1..13 plus suit 0..3 so the rank is read off directly
  logic [3:0] pos_rank, scan_rank;
  logic [1:0] pos_suit, scan_suit;
  logic       scan_used;
`ifdef CARD_SHOE_TRACK_EN
  logic [51:0] used;
  logic [5:0]  scan_idx;
  assign scan_idx  = {4'd0, scan_suit} * 6'd13 + {2'd0, scan_rank} - 6'd1;
  assign scan_used = used[scan_idx];
`else
  assign scan_used = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state          <= IDLE;
      pos_rank       <= 4'd1;
      pos_suit       <= 2'd0;
      scan_rank      <= 4'd1;
      scan_suit      <= 2'd0;
      bus.new_card   <= 4'd0;
      bus.deal_ack   <= 1'b0;
      bus.cards_left <= 6'd52;
      bus.shoe_empty <= 1'b0;
`ifdef CARD_SHOE_TRACK_EN
      used           <= '0;
`endif
    end else begin
      // the 2-bit suit wraps 3->0 on its own, giving the 51->0 position wrap
      pos_rank <= pos_rank == 4'd13 ? 4'd1 : pos_rank + 4'd1;
      pos_suit <= pos_rank == 4'd13 ? pos_suit + 2'd1 : pos_suit;
      case (state)
        IDLE: begin
          if (bus.reshuffle) begin
            bus.cards_left <= 6'd52;
`ifdef CARD_SHOE_TRACK_EN
            used           <= '0;
`endif
          end else if (bus.deal_req && bus.cards_left != 6'd0) begin
            scan_rank <= pos_rank;
            scan_suit <= pos_suit;
            state     <= SEARCH;
          end else if (bus.cards_left == 6'd0) begin
            bus.shoe_empty <= 1'b1;
            state          <= EMPTY;
          end
        end
        SEARCH: begin
          if (!scan_used) begin
`ifdef CARD_SHOE_TRACK_EN
            used[scan_idx] <= 1'b1;
            bus.cards_left <= bus.cards_left - 6'd1;
`endif
            bus.new_card <= scan_rank;
            bus.deal_ack <= 1'b1;
            state        <= ACK;
          end else begin
            scan_rank <= scan_rank == 4'd13 ? 4'd1 : scan_rank + 4'd1;
            scan_suit <= scan_rank == 4'd13 ? scan_suit + 2'd1 : scan_suit;
          end
        end
        ACK: begin
          if (!bus.deal_req) begin
            bus.deal_ack <= 1'b0;
            state        <= IDLE;
          end
        end
        EMPTY: begin
          if (bus.reshuffle) begin
            bus.cards_left <= 6'd52;
            bus.shoe_empty <= 1'b0;
`ifdef CARD_SHOE_TRACK_EN
            used           <= '0;
`endif
            state          <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
